keypad_regs: RTL and testbench

- GBA keypad register block, directly downstream of the PS/2 scan-code decoder.
- Consumes the decoder's 10-bit active-low key-state vector and synchronises and debounces each key.
- Exposes KEYINPUT (0x04000130) and KEYCNT (0x04000132) on the halfword I/O bus.
- Evaluates the KEYCNT condition and emits a one-cycle keypad interrupt request to the interrupt controller.

---
 rtl/keypad_pkg.sv | 18 +
 rtl/key_debounce.sv | 37 +++
 rtl/keypad_regs.sv | 73 +++++++
 tb/tb_keypad_regs.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key indices, KEYCNT field positions and reset values for the GBA keypad block
package keypad_pkg;
   localparam int KEY_A      = 0;
   localparam int KEY_B      = 1;
   localparam int KEY_SELECT = 2;
   localparam int KEY_START  = 3;
   localparam int KEY_RIGHT  = 4;
   localparam int KEY_LEFT   = 5;
   localparam int KEY_UP     = 6;
   localparam int KEY_DOWN   = 7;
   localparam int KEY_R      = 8;
   localparam int KEY_L      = 9;
   localparam int NUM_KEYS   = 10;
   localparam int KEYCNT_IRQ_EN = 14;
   localparam int KEYCNT_AND    = 15;
   localparam logic [15:0] KEYINPUT_RST = 16'h03FF;
   localparam logic [15:0] KEYCNT_RST   = 16'h0000;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchroniser chain plus stability counter for one active-low key
//   clk, rst : clock, synchronous active-high reset
//   i_key_n  : raw key level (0 = pressed)
//   o_k      : debounced key level, resets to 1 (released)
module key_debounce #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key_n,
   output logic o_k
);
   localparam int CW = $clog2(STABLE_CYCLES) + 1;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_k;
   logic                   w_s;
   assign w_s = r_sync[SYNC_STAGES-1];
   assign o_k = r_k;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
         r_cnt  <= '0;
         r_k    <= 1'b1;
      end else begin
         r_sync[0] <= i_key_n;
         for (int j = 1; j < SYNC_STAGES; j++) r_sync[j] <= r_sync[j-1];
         // the counter only runs while the synchronised level disagrees with k
         if (w_s == r_k) r_cnt <= '0;
         else if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
            r_k   <= w_s;
            r_cnt <= '0;
         end else r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/keypad_regs.sv
// keypad_regs: KEYINPUT/KEYCNT registers with per-key debounce and keypad IRQ pulse
//   clk, rst   : clock, synchronous active-high reset
//   key_n      : raw active-low key vector (A,B,Select,Start,Right,Left,Up,Down,R,L)
//   io_sel/io_addr/io_wr/io_be/io_wdata : halfword bus (addr 0 = KEYINPUT, 1 = KEYCNT)
//   io_rdata   : registered read data, 1-cycle latency
//   irq_keypad : one-cycle pulse on a rising edge of the enabled KEYCNT condition
//   keys_dbg   : debounced key vector
module keypad_regs
   import keypad_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  key_n,
   input  logic        io_sel,
   input  logic        io_addr,
   input  logic        io_wr,
   input  logic [1:0]  io_be,
   input  logic [15:0] io_wdata,
   output logic [15:0] io_rdata,
   output logic        irq_keypad,
   output logic [9:0]  keys_dbg
);
   logic [NUM_KEYS-1:0] w_k, w_hit;
   logic [NUM_KEYS-1:0] r_sel;
   logic                r_en, r_and, r_cond_q, r_irq;
   logic [15:0]         r_rdata;
   logic [15:0]         w_keycnt, w_keyinput;
   logic                w_wr_cnt, w_cond, w_live;
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_db (
         .clk    (clk),
         .rst    (rst),
         .i_key_n(key_n[i]),
         .o_k    (w_k[i])
      );
   end
   assign w_keyinput = {6'b0, w_k};
   assign w_keycnt   = {r_and, r_en, 4'b0, r_sel};
   assign w_wr_cnt   = io_sel && io_wr && io_addr;
   assign w_hit      = ~w_k & r_sel;
   // an empty mask must never satisfy AND mode
   assign w_cond     = r_and ? (r_sel != '0) && (w_hit == r_sel) : |w_hit;
   assign w_live     = w_cond && r_en;
   assign io_rdata   = r_rdata;
   assign irq_keypad = r_irq;
   assign keys_dbg   = w_k;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel    <= KEYCNT_RST[9:0];
         r_en     <= KEYCNT_RST[KEYCNT_IRQ_EN];
         r_and    <= KEYCNT_RST[KEYCNT_AND];
         r_rdata  <= 16'h0000;
         r_cond_q <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr_cnt && io_be[0]) r_sel[7:0] <= io_wdata[7:0];
         if (w_wr_cnt && io_be[1]) begin
            r_sel[9:8] <= io_wdata[9:8];
            r_en       <= io_wdata[KEYCNT_IRQ_EN];
            r_and      <= io_wdata[KEYCNT_AND];
         end
         if (io_sel && !io_wr) r_rdata <= io_addr ? w_keycnt : w_keyinput;
         r_cond_q <= w_live;
         r_irq    <= w_live && !r_cond_q;
      end
   end
endmodule

// File: tb/tb_keypad_regs.sv
// tb_keypad_regs: scenario tasks with a read-data scoreboard for keypad_regs
module tb_keypad_regs;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  key_n = '1;
   logic        io_sel = 1'b0, io_addr = 1'b0, io_wr = 1'b0;
   logic [1:0]  io_be = 2'b00;
   logic [15:0] io_wdata = '0;
   logic [15:0] io_rdata;
   logic        irq_keypad;
   logic [9:0]  keys_dbg;
   int          checks = 0, errors = 0, irq_cnt = 0;
   logic        rd_seen = 1'b0;
   logic [15:0] exp_q[$];
   string       name_q[$];

   keypad_regs #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .key_n(key_n), .io_sel(io_sel), .io_addr(io_addr),
      .io_wr(io_wr), .io_be(io_be), .io_wdata(io_wdata), .io_rdata(io_rdata),
      .irq_keypad(irq_keypad), .keys_dbg(keys_dbg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_seen <= io_sel && !io_wr && !rst;

   always @(negedge clk) begin
      if (irq_keypad === 1'b1) irq_cnt++;
      if (rd_seen) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got %h with no expected value queued", io_rdata);
         end else begin
            automatic logic [15:0] e = exp_q.pop_front();
            automatic string n = name_q.pop_front();
            if (io_rdata !== e) begin
               errors++;
               $display("FAIL %s: io_rdata=%h expected %h", n, io_rdata, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic a, input logic [1:0] be, input logic [15:0] d);
      io_sel = 1'b1; io_wr = 1'b1; io_addr = a; io_be = be; io_wdata = d;
      @(negedge clk);
      io_sel = 1'b0; io_wr = 1'b0; io_be = 2'b00;
   endtask

   task automatic bus_read(input logic a, input logic [15:0] e, input string n);
      io_sel = 1'b1; io_wr = 1'b0; io_addr = a;
      exp_q.push_back(e);
      name_q.push_back(n);
      @(negedge clk);
      io_sel = 1'b0;
   endtask

   task automatic test_reset();
      int base;
      @(negedge clk);
      rst = 1'b1; key_n = '1;
      cyc(3);
      rst = 1'b0;
      checks++;
      if (keys_dbg !== 10'h3FF) begin errors++; $display("FAIL reset_keys: got %h expected 3ff", keys_dbg); end
      checks++;
      if (io_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", io_rdata); end
      base = irq_cnt;
      bus_read(1'b0, 16'h03FF, "reset_keyinput");
      bus_read(1'b1, 16'h0000, "reset_keycnt");
      cyc(3);
      checks++;
      if (irq_cnt - base !== 0) begin errors++; $display("FAIL reset_irq: pulses=%0d expected 0", irq_cnt - base); end
   endtask

   task automatic test_debounce();
      key_n[0] = 1'b0;
      cyc(5);
      checks++;
      if (keys_dbg[0] !== 1'b1) begin errors++; $display("FAIL deb_at5: got %b expected 1", keys_dbg[0]); end
      cyc(1);
      checks++;
      if (keys_dbg[0] !== 1'b0) begin errors++; $display("FAIL deb_at6: got %b expected 0", keys_dbg[0]); end
      bus_read(1'b0, 16'h03FE, "deb_keyinput");
      key_n[0] = 1'b1;
      cyc(8);
      checks++;
      if (keys_dbg !== 10'h3FF) begin errors++; $display("FAIL deb_release: got %h expected 3ff", keys_dbg); end
   endtask

   task automatic test_glitch();
      int bad = 0;
      key_n[1] = 1'b0;
      cyc(3);
      key_n[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (keys_dbg !== 10'h3FF) bad++;
         cyc(1);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL glitch: %0d cycles with keys_dbg changed, expected 0", bad); end
      bus_read(1'b0, 16'h03FF, "glitch_keyinput");
   endtask

   task automatic test_or_irq();
      int base;
      bus_write(1'b1, 2'b11, 16'h4003);
      bus_read(1'b1, 16'h4003, "or_keycnt");
      base = irq_cnt;
      key_n[1] = 1'b0;
      cyc(6);
      checks++;
      if (irq_keypad !== 1'b0) begin errors++; $display("FAIL or_irq_early: got %b expected 0", irq_keypad); end
      cyc(1);
      checks++;
      if (irq_keypad !== 1'b1) begin errors++; $display("FAIL or_irq_pulse: got %b expected 1", irq_keypad); end
      cyc(1);
      checks++;
      if (irq_keypad !== 1'b0) begin errors++; $display("FAIL or_irq_width: got %b expected 0", irq_keypad); end
      cyc(100);
      checks++;
      if (irq_cnt - base !== 1) begin errors++; $display("FAIL or_irq_held: pulses=%0d expected 1", irq_cnt - base); end
      key_n[1] = 1'b1;
      cyc(20);
      key_n[1] = 1'b0;
      cyc(20);
      checks++;
      if (irq_cnt - base !== 2) begin errors++; $display("FAIL or_irq_repress: pulses=%0d expected 2", irq_cnt - base); end
      key_n[1] = 1'b1;
      cyc(10);
   endtask

   task automatic test_and_irq();
      int base;
      bus_write(1'b1, 2'b11, 16'hC300);
      base = irq_cnt;
      key_n[8] = 1'b0;
      cyc(20);
      checks++;
      if (irq_cnt - base !== 0) begin errors++; $display("FAIL and_partial: pulses=%0d expected 0", irq_cnt - base); end
      key_n[9] = 1'b0;
      cyc(20);
      checks++;
      if (irq_cnt - base !== 1) begin errors++; $display("FAIL and_full: pulses=%0d expected 1", irq_cnt - base); end
      bus_write(1'b1, 2'b11, 16'h8300);
      cyc(5);
      checks++;
      if (irq_cnt - base !== 1) begin errors++; $display("FAIL and_disable: pulses=%0d expected 1", irq_cnt - base); end
      bus_write(1'b1, 2'b11, 16'hC300);
      cyc(5);
      checks++;
      if (irq_cnt - base !== 2) begin errors++; $display("FAIL and_reenable: pulses=%0d expected 2", irq_cnt - base); end
      bus_read(1'b0, 16'h00FF, "and_keyinput");
      key_n[9:8] = 2'b11;
      cyc(10);
   endtask

   task automatic test_byte_en();
      bus_write(1'b1, 2'b11, 16'h0000);
      bus_read(1'b1, 16'h0000, "be_clear");
      bus_write(1'b1, 2'b01, 16'hFFFF);
      bus_read(1'b1, 16'h00FF, "be_low");
      bus_write(1'b1, 2'b10, 16'hFFFF);
      bus_read(1'b1, 16'hC3FF, "be_high");
      bus_write(1'b0, 2'b11, 16'h0000);
      bus_read(1'b0, 16'h03FF, "keyinput_ro");
   endtask

   task automatic test_back_to_back();
      bus_read(1'b1, 16'hC3FF, "b2b_0");
      bus_read(1'b0, 16'h03FF, "b2b_1");
      bus_read(1'b1, 16'hC3FF, "b2b_2");
      cyc(2);
   endtask

   task automatic test_reset_mid();
      int base;
      bus_write(1'b1, 2'b11, 16'h4001);
      base = irq_cnt;
      key_n[0] = 1'b0;
      cyc(10);
      checks++;
      if (irq_cnt - base !== 1) begin errors++; $display("FAIL mid_pre: pulses=%0d expected 1", irq_cnt - base); end
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      checks++;
      if (keys_dbg !== 10'h3FF || io_rdata !== 16'h0000 || irq_keypad !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: keys=%h rdata=%h irq=%b expected 3ff 0000 0", keys_dbg, io_rdata, irq_keypad);
      end
      bus_read(1'b1, 16'h0000, "mid_keycnt");
      cyc(10);
      checks++;
      if (irq_cnt - base !== 1) begin errors++; $display("FAIL mid_post: pulses=%0d expected 1", irq_cnt - base); end
      checks++;
      if (keys_dbg[0] !== 1'b0) begin errors++; $display("FAIL mid_redeb: got %b expected 0", keys_dbg[0]); end
      key_n[0] = 1'b1;
      cyc(10);
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_or_irq();
      test_and_irq();
      test_byte_en();
      test_back_to_back();
      test_reset_mid();
      cyc(3);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d reads outstanding, expected 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
